// File: rtl/raster_cmd_issuer_pkg.sv
// Shared definitions for the rasterizer command bus.
// The rasterizer side uses the same command codes and field widths.
//   cmd_e        : 2-bit command code (NOP/POINT/LINE/RECT)
//   rast_cmd_t   : one assembled command (cmd + six 3-bit fields, 20 bits)
//   asm_state_e  : byte assembler states
//   iss_state_e  : issuer FSM states
//   build_cmd    : header/argument bytes -> assembled command, unused fields zero
package raster_cmd_issuer_pkg;

  localparam int COORD_W          = 3;
  localparam int CMD_W            = 2;
  localparam int FIFO_DEPTH_DEF   = 2;
  localparam int FRAME_PIXELS_DEF = 64;
  localparam int SYNC_TIMEOUT_DEF = 15;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP   = 2'b00,
    CMD_POINT = 2'b01,
    CMD_LINE  = 2'b10,
    CMD_RECT  = 2'b11
  } cmd_e;

  typedef struct packed {
    cmd_e               cmd;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] width;
    logic [COORD_W-1:0] height;
  } rast_cmd_t;

  localparam int CMD_ENTRY_W = $bits(rast_cmd_t);

  typedef enum logic {
    A_HDR,
    A_ARG
  } asm_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SYNC,
    S_DRAIN
  } iss_state_e;

  function automatic logic is_two_byte(input cmd_e c);
    return (c == CMD_LINE) || (c == CMD_RECT);
  endfunction

  // arg carries only the six payload bits; its top two bits have no meaning.
  function automatic rast_cmd_t build_cmd(input logic [7:0] hdr, input logic [5:0] arg);
    rast_cmd_t c;
    c        = '0;
    c.cmd    = cmd_e'(hdr[7:6]);
    c.x1     = hdr[5:3];
    c.y1     = hdr[2:0];
    if (c.cmd == CMD_LINE) begin
      c.x2 = arg[5:3];
      c.y2 = arg[2:0];
    end
    if (c.cmd == CMD_RECT) begin
      c.width  = arg[5:3];
      c.height = arg[2:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/raster_cmd_issuer_cmd_fifo.sv
// Synchronous show-ahead FIFO for assembled commands.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : push (ignored when full)
//   rd_en/rd_data : pop (ignored when empty); rd_data shows the head entry
//   full, empty   : flags decoded from the registered occupancy count
module raster_cmd_issuer_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      // simultaneous push and pop leaves occupancy unchanged
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/raster_cmd_issuer.sv
// Transmit side of the rasterizer command bus.
// Assembles 1- or 2-byte commands from a byte stream into a small FIFO and
// issues them one at a time, paced by the rasterizer's frame_sync and the
// fixed pixel readout that follows it.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : command byte stream; accepted when in_valid && in_ready
//   in_ready            : FIFO has room
//   out_cmd, out_x1..   : current command, held from load until the next pop
//   cmd_ready           : one-cycle issue strobe
//   frame_sync          : rasterizer draw-done pulse
//   busy                : issued command not yet fully drawn
//   err_timeout         : sticky, frame_sync did not arrive in time
//
// Issuer states
//   state        | meaning
//   S_IDLE       | rasterizer idle; pop and load the next command if any
//   S_ISSUE      | cmd_ready high for this single cycle
//   S_WAIT_SYNC  | waiting for frame_sync, bounded by SYNC_TIMEOUT
//   S_DRAIN      | pixel readout after frame_sync still running
module raster_cmd_issuer
  import raster_cmd_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,  // must be >= 2
  parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF   // must be >= 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [CMD_W-1:0]   out_cmd,
  output logic [COORD_W-1:0] out_x1,
  output logic [COORD_W-1:0] out_y1,
  output logic [COORD_W-1:0] out_x2,
  output logic [COORD_W-1:0] out_y2,
  output logic [COORD_W-1:0] out_width,
  output logic [COORD_W-1:0] out_height,
  output logic               cmd_ready,
  input  logic               frame_sync,
  output logic               busy,
  output logic               err_timeout
);

  localparam int CNT_MAX = (FRAME_PIXELS > SYNC_TIMEOUT) ? FRAME_PIXELS : SYNC_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Both timers are down-counters ending at zero. The state that loads them
  // is itself one cycle of the interval, hence the -2.
  localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(FRAME_PIXELS - 2);

  asm_state_e asm_state;
  logic [7:0] hdr_q;
  logic       accept;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  rast_cmd_t  push_cmd;
  rast_cmd_t  pop_cmd;
  cmd_e       in_cmd;

  iss_state_e       iss_state;
  logic [CNT_W-1:0] cnt;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign in_cmd   = cmd_e'(in_data[7:6]);
  assign fifo_pop = (iss_state == S_IDLE) && !fifo_empty;

  // ---------------- byte assembler ----------------
  always_comb begin
    fifo_push = 1'b0;
    push_cmd  = '0;
    if (accept) begin
      if (asm_state == A_ARG) begin
        fifo_push = 1'b1;
        push_cmd  = build_cmd(hdr_q, in_data[5:0]);
      end else if (!is_two_byte(in_cmd)) begin
        fifo_push = 1'b1;
        push_cmd  = build_cmd(in_data, 6'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_state <= A_HDR;
      hdr_q     <= '0;
    end else if (accept) begin
      if (asm_state == A_HDR && is_two_byte(in_cmd)) begin
        asm_state <= A_ARG;
        hdr_q     <= in_data;
      end else begin
        asm_state <= A_HDR;
      end
    end
  end

  raster_cmd_issuer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_ENTRY_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_push),
    .wr_data (push_cmd),
    .rd_en   (fifo_pop),
    .rd_data (pop_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- issuer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_state   <= S_IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
      out_cmd     <= '0;
      out_x1      <= '0;
      out_y1      <= '0;
      out_x2      <= '0;
      out_y2      <= '0;
      out_width   <= '0;
      out_height  <= '0;
    end else begin
      cmd_ready <= 1'b0;
      case (iss_state)
        S_IDLE: begin
          if (!fifo_empty) begin
            out_cmd    <= pop_cmd.cmd;
            out_x1     <= pop_cmd.x1;
            out_y1     <= pop_cmd.y1;
            out_x2     <= pop_cmd.x2;
            out_y2     <= pop_cmd.y2;
            out_width  <= pop_cmd.width;
            out_height <= pop_cmd.height;
            cmd_ready  <= 1'b1;
            busy       <= 1'b1;
            iss_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt       <= SYNC_LOAD;
          iss_state <= S_WAIT_SYNC;
        end
        S_WAIT_SYNC: begin
          // a frame_sync on the last allowed cycle still wins over the timeout
          if (frame_sync) begin
            cnt       <= DRAIN_LOAD;
            iss_state <= S_DRAIN;
          end else if (cnt == '0) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            iss_state   <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == '0) begin
            busy      <= 1'b0;
            iss_state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: iss_state <= S_IDLE;
      endcase
    end
  end

endmodule
